demo_slave_port: RTL

//  Responder end of the bit-serial system bus: receives LSB-first address/data frames, executes a read or

---
 rtl/demo_slave_port_pkg.sv | 31 +++
 rtl/demo_slave_port_slave_bram.sv | 28 ++
 rtl/demo_slave_port.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demo_slave_port_pkg.sv
// Shared bus definitions for the bit-serial system bus (master and slave ports).
// Contents:
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default frame field widths
//   MODE_READ / MODE_WRITE          : values carried on smode in the first frame bit
//   state_e                         : responder FSM state encoding
//   cnt_width()                     : bit-counter width for a given pair of field widths
package demo_slave_port_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WR    = 3'd3,
        ST_RD1   = 3'd4,
        ST_RD2   = 3'd5,
        ST_RDATA = 3'd6
    } state_e;

    // One spare bit above what the longest field needs, so a counter can hold
    // the full field length without wrapping.
    function automatic int cnt_width(input int a_w, input int d_w);
        return $clog2((a_w > d_w) ? a_w : d_w) + 1;
    endfunction

endpackage

// File: rtl/demo_slave_port_slave_bram.sv
// Single-port synchronous byte RAM used as the slave's local memory.
// Ports:
//   clock   : write/read clock
//   address : word address (ADDR_WIDTH bits)
//   data    : write data
//   wren    : write enable, writes data at address on the rising edge
//   q       : registered read data, valid one cycle after address is presented
module demo_slave_port_slave_bram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/demo_slave_port.sv
// Responder end of the bit-serial system bus. Receives LSB-first address and
// (for writes) data frames, performs the access on a local byte memory and
// streams read data back LSB-first.
// Ports:
//   clk    : bus clock, rising edge
//   rstn   : synchronous reset, active high
//   swdata : serial address/write-data bit, LSB first
//   smode  : 0 read / 1 write, taken from the first bit of a frame only
//   mvalid : swdata valid, high for every bit of a frame
//   srdata : serial read-data bit, LSB first
//   svalid : srdata valid
//   sready : high only while idle and able to accept a frame
module demo_slave_port
    import demo_slave_port_pkg::*;
#(
    parameter int SLAVE_MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready
);

    localparam int AW = SLAVE_MEM_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_width(AW, DW);

    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] DATA_DONE = CW'(DW);

    state_e          state_q,   state_d;
    logic [AW-1:0]   addr_q,    addr_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [DW-1:0]   tx_q,      tx_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            mode_q,    mode_d;
    logic            srdata_q,  srdata_d;
    logic            svalid_q,  svalid_d;
    logic            sready_q,  sready_d;
    logic            mem_wen_q, mem_wen_d;
    logic [DW-1:0]   ram_q;

    // The address register feeds the RAM directly; it is stable from the end
    // of the address phase through the read or write cycle.
    demo_slave_port_slave_bram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_bram (
        .clock   (clk),
        .address (addr_q),
        .data    (wdata_q),
        .wren    (mem_wen_q),
        .q       (ram_q)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        srdata_d  = srdata_q;
        svalid_d  = svalid_q;
        mem_wen_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mvalid) begin
                    // Right-shift in at the MSB so bit 0 ends up at the LSB.
                    addr_d  = {swdata, addr_q[AW-1:1]};
                    mode_d  = smode;
                    cnt_d   = CW'(1);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!mvalid) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    addr_d = {swdata, addr_q[AW-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_WRITE) ? ST_WDATA : ST_RD1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_WDATA: begin
                if (!mvalid) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    wdata_d = {swdata, wdata_q[DW-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d     = '0;
                        mem_wen_d = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD1: begin
                state_d = ST_RD2;
            end
            ST_RD2: begin
                // Bit 0 goes straight out; the rest waits in the tx register.
                srdata_d = ram_q[0];
                tx_d     = ram_q >> 1;
                svalid_d = 1'b1;
                cnt_d    = CW'(1);
                state_d  = ST_RDATA;
            end
            ST_RDATA: begin
                if (cnt_q == DATA_DONE) begin
                    srdata_d = 1'b0;
                    svalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    srdata_d = tx_q[0];
                    tx_d     = tx_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            srdata_q  <= 1'b0;
            svalid_q  <= 1'b0;
            sready_q  <= 1'b1;
            mem_wen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            srdata_q  <= srdata_d;
            svalid_q  <= svalid_d;
            sready_q  <= sready_d;
            mem_wen_q <= mem_wen_d;
        end
    end

    assign srdata = srdata_q;
    assign svalid = svalid_q;
    assign sready = sready_q;

endmodule
